sdram_pll_reset_sequencer: RTL

//  Sequences the SDRAM clock PLL: pulses its reset, waits for lock, debounces lock, then releases the

---
 rtl/sdram_pll_reset_sequencer_if.sv | 26 ++
 rtl/sdram_pll_reset_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sdram_pll_reset_sequencer_if.sv
// Control/status bundle between the board-level reset logic and the SDRAM PLL sequencer.
// The sequencer takes the slave view; whoever drives lock and soft reset takes the master view.
interface sdram_pll_reset_sequencer_if #(
  parameter int MAX_RETRIES = 3,
  parameter int RW          = $clog2(MAX_RETRIES + 1)
) ();
  logic          pll_locked;
  logic          soft_reset_req;
  logic          pll_rst;
  logic          sdram_rst;
  logic          ready;
  logic          fault;
  logic          lock_lost;
  logic [RW-1:0] retry_cnt;
  logic [2:0]    state;

  modport master (
    output pll_locked, soft_reset_req,
    input  pll_rst, sdram_rst, ready, fault, lock_lost, retry_cnt, state
  );

  modport slave (
    input  pll_locked, soft_reset_req,
    output pll_rst, sdram_rst, ready, fault, lock_lost, retry_cnt, state
  );
endinterface

// File: rtl/sdram_pll_reset_sequencer.sv
// Pulses the SDRAM PLL reset, waits for a debounced lock, then releases the SDRAM controller.
// Runs on the free-running reference clock; bounded retries end in FAULT.
module sdram_pll_reset_sequencer #(
  parameter int RST_PULSE_CYC    = 10,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int MAX_RETRIES      = 3,
  parameter int CNT_W            = 16
) (
  input  logic                         refclk,
  input  logic                         rst,
  sdram_pll_reset_sequencer_if.slave   bus
);

  localparam int RW = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [RW-1:0]    RETRY_MAX    = RW'(MAX_RETRIES);

  if (RST_PULSE_CYC < 1 || RST_PULSE_CYC > 2**CNT_W) begin : g_bad_pulse
    $error("RST_PULSE_CYC out of range for CNT_W");
  end
  if (LOCK_TIMEOUT_CYC < 1 || LOCK_TIMEOUT_CYC > 2**CNT_W) begin : g_bad_timeout
    $error("LOCK_TIMEOUT_CYC out of range for CNT_W");
  end
  if (LOCK_STABLE_CYC < 1 || LOCK_STABLE_CYC > 2**CNT_W) begin : g_bad_stable
    $error("LOCK_STABLE_CYC out of range for CNT_W");
  end

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             lock_lost_q, lock_lost_d;
  logic             pll_rst_q, sdram_rst_q, ready_q, fault_q;
  logic             locked_s;
  logic             timeout;

  assign locked_s = sync_q[1];
  assign timeout  = (timer_q == TIMEOUT_LAST);

  // NOTE: every variable gets its hold value first, so no path through the case can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    retry_d     = retry_q;
    lock_lost_d = lock_lost_q;

    if (bus.soft_reset_req) begin
      state_d     = S_RESET_PLL;
      cnt_d       = '0;
      timer_d     = '0;
      retry_d     = '0;
      lock_lost_d = 1'b0;
    end else begin
      unique case (state_q)
        S_RESET_PLL: begin
          timer_d = '0;
          if (cnt_q == PULSE_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT_LOCK, S_STABLE: begin
          timer_d = timer_q + CNT_W'(1);
          // A completed stable window beats a timeout on the same edge.
          if (state_q == S_STABLE && locked_s && cnt_q == STABLE_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else if (timeout) begin
            cnt_d   = '0;
            timer_d = '0;
            if (retry_q == RETRY_MAX) begin
              state_d = S_FAULT;
            end else begin
              state_d = S_RESET_PLL;
              retry_d = retry_q + RW'(1);
            end
          end else if (state_q == S_WAIT_LOCK) begin
            if (locked_s) begin
              state_d = S_STABLE;
              cnt_d   = '0;
            end
          end else if (!locked_s) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          cnt_d   = '0;
          timer_d = '0;
          if (!locked_s) begin
            state_d     = S_RESET_PLL;
            lock_lost_d = 1'b1;
          end
        end
        S_FAULT: begin
          cnt_d   = '0;
          timer_d = '0;
        end
        default: state_d = S_RESET_PLL;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RESET_PLL;
      sync_q      <= '0;
      cnt_q       <= '0;
      timer_q     <= '0;
      retry_q     <= '0;
      lock_lost_q <= 1'b0;
      pll_rst_q   <= 1'b1;
      sdram_rst_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[0], bus.pll_locked};
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      lock_lost_q <= lock_lost_d;
      // Outputs decode the next state so they switch on the state-entry edge.
      pll_rst_q   <= (state_d == S_RESET_PLL) || (state_d == S_FAULT);
      sdram_rst_q <= (state_d != S_RUN);
      ready_q     <= (state_d == S_RUN);
      fault_q     <= (state_d == S_FAULT);
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sdram_rst = sdram_rst_q;
  assign bus.ready     = ready_q;
  assign bus.fault     = fault_q;
  assign bus.lock_lost = lock_lost_q;
  assign bus.retry_cnt = retry_q;
  assign bus.state     = state_q;

endmodule
